// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main control FSM for a multi-cycle RISC-V datapath.
// Inputs:  clk, rst_n (async active-low), opcode (IR[6:0]), mem_ready (memory access completes).
// Outputs: datapath control strobes and selects, illegal (unsupported opcode seen in DECODE),
//          state_o (debug state code), instret (retired-instruction count).
module multicycle_main_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 PCSource,
  output logic                 illegal,
  output logic [3:0]           state_o,
  output logic [CNT_WIDTH-1:0] instret
);
  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10
  } state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic is_r, is_i, is_ld, is_sd, is_beq;
  logic fetch, decode, mem_addr, mem_read, mem_wb, mem_write, exec_r, exec_i, alu_wb, branch;
  logic retire;
  assign is_r   = opcode == 7'b0110011;
  assign is_i   = opcode == 7'b0010011;
  assign is_ld  = opcode == 7'b0000011;
  assign is_sd  = opcode == 7'b0100011;
  assign is_beq = opcode == 7'b1100011;
  assign fetch     = state_q == S_FETCH;
  assign decode    = state_q == S_DECODE;
  assign mem_addr  = state_q == S_MEM_ADDR;
  assign mem_read  = state_q == S_MEM_READ;
  assign mem_wb    = state_q == S_MEM_WB;
  assign mem_write = state_q == S_MEM_WRITE;
  assign exec_r    = state_q == S_EXEC_R;
  assign exec_i    = state_q == S_EXEC_I;
  assign alu_wb    = state_q == S_ALU_WB;
  assign branch    = state_q == S_BRANCH;
  // A store only retires once memory accepts it; every other final state always retires.
  assign retire = mem_wb | alu_wb | branch | (mem_write & mem_ready);
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = is_r ? S_EXEC_R : is_i ? S_EXEC_I : (is_ld | is_sd) ? S_MEM_ADDR :
                             is_beq ? S_BRANCH : S_FETCH;
      S_MEM_ADDR:  state_d = is_ld ? S_MEM_READ : is_sd ? S_MEM_WRITE : S_FETCH;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      default:     state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_q + CNT_WIDTH'(retire);
    end
  end
  // Outputs decode from the registered state, so the async reset clears them at once.
  assign MemRead     = fetch | mem_read;
  assign MemWrite    = mem_write;
  assign IorD        = mem_read | mem_write;
  assign IRWrite     = fetch & mem_ready;
  assign PCWrite     = fetch & mem_ready;
  assign MemtoReg    = mem_wb;
  assign RegWrite    = mem_wb | alu_wb;
  assign ALUSrcA     = decode ? 2'b10 : (mem_addr | exec_r | exec_i | branch) ? 2'b01 : 2'b00;
  assign ALUSrcB     = fetch ? 2'b01 : (decode | mem_addr | exec_i) ? 2'b10 : 2'b00;
  assign ALUOp       = exec_r ? 2'b10 : branch ? 2'b01 : 2'b00;
  assign PCSource    = branch;
  assign PCWriteCond = branch;
  assign illegal     = decode & ~(is_r | is_i | is_ld | is_sd | is_beq);
  assign state_o     = state_q;
  assign instret     = instret_q;
endmodule
